// File: rtl/rsa_operand_loader.sv
// rsa_operand_loader
//   Front-end stage for the RSA modular-exponentiation core. It collects the
//   c, e and n operands from narrow host word writes. When a start request
//   arrives it holds the operands stable, pulses the core reset for one
//   cycle so the core captures c, and then raises enable until the core
//   reports finish. It also counts the cycles spent running the core.
//
//   Optional feature macro: RSA_LOADER_MSW_FIRST_EN
//     Defined   : the first word written to an operand lands in the top slot
//                 (WORDS-1), and the pointer counts down.
//     Undefined : the first word lands in slot 0, and the pointer counts up.
//
// Ports
//   clk          system clock, rising edge
//   sys_rst      asynchronous active-high reset
//   wr_valid     host write request
//   wr_ready     high when a write can be accepted (LOAD state only)
//   wr_sel       operand select: 0=c, 1=e, 2=n, 3=illegal
//   wr_data      write word
//   start        exponentiation request, sampled in LOAD only
//   c_out        operand c to the core
//   e_out        exponent e to the core
//   n_out        modulus n to the core
//   core_rst     core reset, high for one cycle before a run
//   core_enable  core enable, high during RUN
//   core_finish  finish flag from the core
//   loaded       per-operand complete flags {n, e, c}
//   busy         high in CORE_RST and RUN
//   done         one-cycle pulse when the core finishes
//   err          one-cycle pulse on an illegal write or a premature start
//   run_cycles   RUN cycles of the last operation, saturating

module rsa_operand_loader #(
    parameter int unsigned WIDTH  = 2048,
    parameter int unsigned WORD_W = 32
) (
    input  logic              clk,
    input  logic              sys_rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [1:0]        wr_sel,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              start,
    output logic [WIDTH-1:0]  c_out,
    output logic [WIDTH-1:0]  e_out,
    output logic [WIDTH-1:0]  n_out,
    output logic              core_rst,
    output logic              core_enable,
    input  logic              core_finish,
    output logic [2:0]        loaded,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       run_cycles
);

    localparam int unsigned WORDS = WIDTH / WORD_W;
    localparam int unsigned PTR_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned NOPS  = 3;

`ifdef RSA_LOADER_MSW_FIRST_EN
    localparam logic [PTR_W-1:0] PTR_FIRST = PTR_W'(WORDS - 1);
    localparam logic [PTR_W-1:0] PTR_LAST  = '0;
    localparam bit               PTR_DOWN  = 1'b1;
`else
    localparam logic [PTR_W-1:0] PTR_FIRST = '0;
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(WORDS - 1);
    localparam bit               PTR_DOWN  = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_LOAD     = 2'd0,
        S_CORE_RST = 2'd1,
        S_RUN      = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   op_q  [NOPS];
    logic [WIDTH-1:0]   op_d  [NOPS];
    logic [PTR_W-1:0]   ptr_q [NOPS];
    logic [PTR_W-1:0]   ptr_d [NOPS];
    logic [2:0]         loaded_q, loaded_d;
    logic               wr_ready_q, wr_ready_d;
    logic               core_rst_q, core_rst_d;
    logic               core_enable_q, core_enable_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [31:0]        run_cycles_q, run_cycles_d;

    logic               wr_fire;

    // wr_ready is only ever high in LOAD, so an accepted write implies LOAD.
    assign wr_fire = wr_valid && wr_ready_q;

    // Next-state, operand update and registered-output decode.
    always_comb begin
        state_d      = state_q;
        loaded_d     = loaded_q;
        err_d        = 1'b0;
        run_cycles_d = run_cycles_q;
        for (int s = 0; s < int'(NOPS); s++) begin
            op_d[s]  = op_q[s];
            ptr_d[s] = ptr_q[s];
        end

        case (state_q)
            S_LOAD: begin
                if (wr_fire) begin
                    if (wr_sel == 2'd3) begin
                        err_d = 1'b1;
                    end else begin
                        for (int s = 0; s < int'(NOPS); s++) begin
                            if (wr_sel == 2'(s)) begin
                                for (int w = 0; w < int'(WORDS); w++) begin
                                    if (ptr_q[s] == PTR_W'(w)) begin
                                        op_d[s][w*WORD_W +: WORD_W] = wr_data;
                                    end
                                end
                                if (ptr_q[s] == PTR_LAST) begin
                                    ptr_d[s]    = PTR_FIRST;
                                    loaded_d[s] = 1'b1;
                                end else if (PTR_DOWN) begin
                                    ptr_d[s] = ptr_q[s] - PTR_W'(1);
                                end else begin
                                    ptr_d[s] = ptr_q[s] + PTR_W'(1);
                                end
                            end
                        end
                    end
                end
                // The start decision uses loaded before any same-cycle write.
                if (start) begin
                    if (loaded_q == 3'b111) begin
                        state_d      = S_CORE_RST;
                        run_cycles_d = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_CORE_RST: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (run_cycles_q != 32'hFFFF_FFFF) begin
                    run_cycles_d = run_cycles_q + 32'd1;
                end
                if (core_finish) begin
                    state_d  = S_DONE;
                    loaded_d = '0;
                end
            end
            S_DONE: begin
                state_d = S_LOAD;
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase

        // Outputs are decoded from the next state so they line up with it.
        wr_ready_d    = (state_d == S_LOAD);
        core_rst_d    = (state_d == S_CORE_RST);
        core_enable_d = (state_d == S_RUN);
        busy_d        = (state_d == S_CORE_RST) || (state_d == S_RUN);
        done_d        = (state_d == S_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q       <= S_LOAD;
            loaded_q      <= '0;
            wr_ready_q    <= 1'b1;
            core_rst_q    <= 1'b0;
            core_enable_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            run_cycles_q  <= '0;
            for (int s = 0; s < int'(NOPS); s++) begin
                op_q[s]  <= '0;
                ptr_q[s] <= PTR_FIRST;
            end
        end else begin
            state_q       <= state_d;
            loaded_q      <= loaded_d;
            wr_ready_q    <= wr_ready_d;
            core_rst_q    <= core_rst_d;
            core_enable_q <= core_enable_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
            run_cycles_q  <= run_cycles_d;
            for (int s = 0; s < int'(NOPS); s++) begin
                op_q[s]  <= op_d[s];
                ptr_q[s] <= ptr_d[s];
            end
        end
    end

    assign c_out       = op_q[0];
    assign e_out       = op_q[1];
    assign n_out       = op_q[2];
    assign loaded      = loaded_q;
    assign wr_ready    = wr_ready_q;
    assign core_rst    = core_rst_q;
    assign core_enable = core_enable_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign run_cycles  = run_cycles_q;

endmodule

// File: tb/tb_rsa_operand_loader.sv
// Directed bench for rsa_operand_loader: loading, sequencing, error pulses,
// mid-run reset and pointer reset. Expectations are hand values plus a small
// operand model kept by the bench from its own writes.
module tb_rsa_operand_loader;

    localparam int WIDTH  = 2048;
    localparam int WORD_W = 32;
    localparam int WORDS  = WIDTH / WORD_W;

    logic              clk = 1'b0;
    logic              sys_rst;
    logic              wr_valid;
    logic              wr_ready;
    logic [1:0]        wr_sel;
    logic [WORD_W-1:0] wr_data;
    logic              start;
    logic [WIDTH-1:0]  c_out, e_out, n_out;
    logic              core_rst, core_enable, core_finish;
    logic [2:0]        loaded;
    logic              busy, done, err;
    logic [31:0]       run_cycles;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] exp_op [3];
    int               mptr   [3];

    rsa_operand_loader #(.WIDTH(WIDTH), .WORD_W(WORD_W)) dut (
        .clk(clk), .sys_rst(sys_rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_sel(wr_sel), .wr_data(wr_data),
        .start(start),
        .c_out(c_out), .e_out(e_out), .n_out(n_out),
        .core_rst(core_rst), .core_enable(core_enable), .core_finish(core_finish),
        .loaded(loaded), .busy(busy), .done(done), .err(err), .run_cycles(run_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Slot that the model pointer maps to under the current build.
    function automatic int slot_of(input int p);
`ifdef RSA_LOADER_MSW_FIRST_EN
        return WORDS - 1 - p;
`else
        return p;
`endif
    endfunction

    task automatic model_write(input int sel, input logic [WORD_W-1:0] d);
        exp_op[sel][slot_of(mptr[sel])*WORD_W +: WORD_W] = d;
        mptr[sel] = (mptr[sel] + 1) % WORDS;
    endtask

    task automatic model_clear();
        for (int s = 0; s < 3; s++) begin
            exp_op[s] = '0;
            mptr[s]   = 0;
        end
    endtask

    task automatic wr(input logic [1:0] sel, input logic [WORD_W-1:0] d);
        wr_valid = 1'b1;
        wr_sel   = sel;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
        if (sel != 2'd3) model_write(int'(sel), d);
    endtask

    task automatic load_op(input logic [1:0] sel, input logic [WORD_W-1:0] base);
        for (int k = 0; k < WORDS; k++) wr(sel, base + WORD_W'(k));
    endtask

    initial begin
        logic [31:0] lo_first, hi_first;
`ifdef RSA_LOADER_MSW_FIRST_EN
        lo_first = 32'd64; hi_first = 32'd1;
`else
        lo_first = 32'd1;  hi_first = 32'd64;
`endif
        model_clear();
        sys_rst = 1'b1; wr_valid = 1'b0; wr_sel = 2'd0; wr_data = '0;
        start = 1'b0; core_finish = 1'b0;
        #2;
        check("rst_c_out",   64'(c_out == '0), 64'd1);
        check("rst_loaded",  64'(loaded), 64'd0);
        check("rst_enable",  64'(core_enable), 64'd0);
        check("rst_cycles",  64'(run_cycles), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        sys_rst = 1'b0;
        tick();
        check("rst_wr_ready", 64'(wr_ready), 64'd1);

        // Full load, word k = k+1.
        load_op(2'd0, 32'd1);
        load_op(2'd1, 32'd1);
        load_op(2'd2, 32'd1);
        check("load_all",    64'(loaded), 64'd7);
        check("load_c_lo",   64'(c_out[31:0]), 64'(lo_first));
        check("load_c_hi",   64'(c_out[2047:2016]), 64'(hi_first));
        check("load_c_full", 64'(c_out == exp_op[0]), 64'd1);
        check("load_e_full", 64'(e_out == exp_op[1]), 64'd1);
        check("load_n_full", 64'(n_out == exp_op[2]), 64'd1);
        check("load_no_err", 64'(err), 64'd0);

        // Illegal select.
        wr(2'd3, 32'hDEADBEEF);
        check("sel3_err",    64'(err), 64'd1);
        check("sel3_c",      64'(c_out == exp_op[0]), 64'd1);
        check("sel3_e",      64'(e_out == exp_op[1]), 64'd1);
        check("sel3_n",      64'(n_out == exp_op[2]), 64'd1);
        check("sel3_loaded", 64'(loaded), 64'd7);
        tick();
        check("sel3_err_drop", 64'(err), 64'd0);

        // Start, core reset pulse, enable latency, run counting.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("crst_high",    64'(core_rst), 64'd1);
        check("crst_en_low",  64'(core_enable), 64'd0);
        check("crst_busy",    64'(busy), 64'd1);
        check("crst_ready",   64'(wr_ready), 64'd0);
        check("crst_cycles",  64'(run_cycles), 64'd0);
        tick();
        check("run_crst_low", 64'(core_rst), 64'd0);
        check("run_enable",   64'(core_enable), 64'd1);
        // Writes attempted during RUN must be ignored.
        wr_valid = 1'b1; wr_sel = 2'd0; wr_data = 32'hCAFEF00D;
        repeat (50) tick();
        wr_valid = 1'b0;
        check("run_mid_cycles", 64'(run_cycles), 64'd50);
        check("run_mid_enable", 64'(core_enable), 64'd1);
        repeat (50) tick();
        core_finish = 1'b1;
        tick();
        core_finish = 1'b0;
        check("fin_done",    64'(done), 64'd1);
        check("fin_cycles",  64'(run_cycles), 64'd101);
        check("fin_loaded",  64'(loaded), 64'd0);
        check("fin_enable",  64'(core_enable), 64'd0);
        check("fin_busy",    64'(busy), 64'd0);
        check("fin_c_frozen", 64'(c_out == exp_op[0]), 64'd1);
        tick();
        check("back_done",   64'(done), 64'd0);
        check("back_ready",  64'(wr_ready), 64'd1);

        // core_finish outside RUN is ignored.
        core_finish = 1'b1;
        tick();
        core_finish = 1'b0;
        check("stray_done",  64'(done), 64'd0);
        check("stray_ready", 64'(wr_ready), 64'd1);

        // Partial load then start: error, no core reset.
        load_op(2'd0, 32'h1000);
        load_op(2'd1, 32'h2000);
        check("part_loaded", 64'(loaded), 64'd3);
        check("part_c_full", 64'(c_out == exp_op[0]), 64'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("part_err",    64'(err), 64'd1);
        check("part_crst",   64'(core_rst), 64'd0);
        check("part_loaded2", 64'(loaded), 64'd3);
        tick();
        check("part_err_drop", 64'(err), 64'd0);

        // Start in the same cycle as the completing write uses stale loaded.
        for (int k = 0; k < WORDS - 1; k++) wr(2'd2, 32'h3000 + 32'(k));
        wr_valid = 1'b1; wr_sel = 2'd2; wr_data = 32'h3000 + 32'(WORDS - 1);
        start = 1'b1;
        tick();
        wr_valid = 1'b0; start = 1'b0;
        model_write(2, 32'h3000 + 32'(WORDS - 1));
        check("same_err",    64'(err), 64'd1);
        check("same_loaded", 64'(loaded), 64'd7);
        check("same_crst",   64'(core_rst), 64'd0);
        check("same_n_full", 64'(n_out == exp_op[2]), 64'd1);

        // Mid-run asynchronous reset.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        check("pre_rst_enable", 64'(core_enable), 64'd1);
        #2;
        sys_rst = 1'b1;
        #1;
        check("arst_enable", 64'(core_enable), 64'd0);
        check("arst_c_zero", 64'(c_out == '0), 64'd1);
        check("arst_loaded", 64'(loaded), 64'd0);
        check("arst_busy",   64'(busy), 64'd0);
        model_clear();
        tick();
        sys_rst = 1'b0;
        tick();
        check("arst_ready",  64'(wr_ready), 64'd1);

        // Pointers restart at the first slot after reset.
        wr(2'd0, 32'd5);
`ifdef RSA_LOADER_MSW_FIRST_EN
        check("ptr_rst_slot", 64'(c_out[2047:2016]), 64'd5);
`else
        check("ptr_rst_slot", 64'(c_out[31:0]), 64'd5);
`endif
        check("ptr_rst_full", 64'(c_out == exp_op[0]), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
